// File: rtl/adder_pipe_nbit_if.sv
// Valid/ready operand and result bus of the chunked pipelined adder.
interface adder_pipe_nbit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, overflow
  );
endinterface

// File: rtl/adder_pipe_nbit.sv
// Pipelined adder: each stage adds one CHUNK-bit slice and passes the carry on.
// Optional feature macro: ADDER_OVF_COUNT_EN adds a saturating overflow_count output.
module adder_pipe_nbit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  adder_pipe_nbit_if.slave  bus
`ifdef ADDER_OVF_COUNT_EN
  ,
  output logic [15:0]       overflow_count
`endif
);

  localparam int unsigned STAGES = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW     = CHUNK + 1;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q,  cy_d;
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [WIDTH-1:0]  rem_a_q [STAGES];
  logic [WIDTH-1:0]  rem_a_d [STAGES];
  logic [WIDTH-1:0]  rem_b_q [STAGES];
  logic [WIDTH-1:0]  rem_b_d [STAGES];
  logic [CW-1:0]     part;
  logic              stall_c;

  // A stall freezes the whole pipe, bubbles included, so nothing is lost or duplicated.
  assign stall_c      = vld_q[STAGES-1] && !bus.out_ready;
  assign bus.in_ready = !stall_c;

  // Stage k sums slice k; unprocessed operand bits are kept right-aligned for the next stage.
  always_comb begin
    part = {1'b0, bus.a[CHUNK-1:0]} + {1'b0, bus.b[CHUNK-1:0]} + CW'(bus.carry_in);
    vld_d[0]   = bus.in_valid;
    cy_d[0]    = part[CHUNK];
    sum_d[0]   = WIDTH'(part[CHUNK-1:0]);
    rem_a_d[0] = bus.a >> CHUNK;
    rem_b_d[0] = bus.b >> CHUNK;
    for (int unsigned k = 1; k < STAGES; k++) begin
      part = {1'b0, rem_a_q[k-1][CHUNK-1:0]} + {1'b0, rem_b_q[k-1][CHUNK-1:0]}
           + CW'(cy_q[k-1]);
      vld_d[k]   = vld_q[k-1];
      cy_d[k]    = part[CHUNK];
      sum_d[k]   = sum_q[k-1] | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));
      rem_a_d[k] = rem_a_q[k-1] >> CHUNK;
      rem_b_d[k] = rem_b_q[k-1] >> CHUNK;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k]   <= '0;
        rem_a_q[k] <= '0;
        rem_b_q[k] <= '0;
      end
    end else if (!stall_c) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k]   <= sum_d[k];
        rem_a_q[k] <= rem_a_d[k];
        rem_b_q[k] <= rem_b_d[k];
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.overflow  = cy_q[STAGES-1];

`ifdef ADDER_OVF_COUNT_EN
  // Counts delivered results that overflowed; sticks at all-ones.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow_count <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.overflow
                 && overflow_count != 16'hFFFF) begin
      overflow_count <= overflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/adder_pipe_nbit.md
ADDER_PIPE_NBIT -- requirements
Module: adder_pipe_nbit

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits summed per pipeline stage.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK; elaboration SHALL fail unless WIDTH%CHUNK==0 and CHUNK>=1.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operands present this cycle.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  unsigned operand A.
REQ-009 b  input  WIDTH  unsigned operand B.
REQ-010 carry_in  input  1  carry into bit 0.
REQ-011 out_valid  output  1  sum/overflow valid.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 sum  output  WIDTH  a+b+carry_in modulo 2^WIDTH.
REQ-014 overflow  output  1  carry out of bit WIDTH-1.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-016 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of a, b with carry from stage k-1 (stage 0 uses carry_in), registering partial sum, carry, and remaining unprocessed operand bits.
REQ-017 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-018 Throughput SHALL be one result per cycle while out_ready stays high.
REQ-019 stall = out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-020 During stall every stage register, including valid bits, SHALL hold; no result SHALL be lost or duplicated.
REQ-021 Bubbles (invalid stages) SHALL advance normally when not stalled; a stage valid bit SHALL be 0 for a bubble.
REQ-022 sum/overflow SHALL hold stable while out_valid && !out_ready.
REQ-023 Results SHALL emerge in acceptance order.
REQ-024 Boundary: all-ones + all-ones + carry_in=1 SHALL give sum all-ones, overflow 1; zero + zero + 0 SHALL give 0, overflow 0.
REQ-025 Carry SHALL ripple across every chunk boundary (e.g. 0x0FFF+0x0001 -> 0x1000).
REQ-026 Simultaneous output transfer and input transfer in one cycle SHALL be supported with no bubble inserted.

Reset
REQ-027 On n_rst low, all stage valid bits, out_valid, sum, overflow SHALL clear to 0 immediately, independent of clk.
REQ-028 in_ready SHALL be 1 while n_rst is low and after release.
REQ-029 Reset mid-operation SHALL discard all in-flight results; first input after release SHALL appear STAGES cycles later.

Configuration
REQ-030 Macro ADDER_OVF_COUNT_EN, when defined, SHALL add output overflow_count [15:0], counting output transfers with overflow=1, saturating at 0xFFFF, reset to 0 by n_rst.
REQ-031 Without ADDER_OVF_COUNT_EN the port and counter logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=16, CHUNK=4, STAGES=4)
REQ-032 a=0x1234, b=0x0FCD, carry_in=0, out_ready=1 -> out_valid exactly 4 cycles later, sum 0x2201, overflow 0.
REQ-033 a=0xFFFF, b=0xFFFF, carry_in=1 -> sum 0xFFFF, overflow 1; with macro, overflow_count increments 0->1 on output transfer.
REQ-034 Back-to-back 8 inputs (a=i, b=i, i=0..7), out_ready=1 -> 8 consecutive outputs sum=2i, in order, in_ready constantly 1.
REQ-035 Hold out_ready=0 for 6 cycles after first result with in_valid=1 -> in_ready 0 while stalled, sum/overflow stable, then all results delivered in order with none lost.
REQ-036 Assert n_rst=0 with 3 results in flight -> out_valid, sum, overflow 0 immediately; after release no stale results appear; new input a=0x0FFF, b=0x0001 yields 0x1000 after 4 cycles.
REQ-037 Randomised exhaustive-style sweep is supplementary; the directed scenarios above SHALL pass with zero $error reports.
